integral_row_sequencer: RTL and testbench
=========================================

# integral_row_sequencer

Raster-scan controller that sequences the pixel stream into the chain of integral-image row blocks. It issues per-pixel write enables and the first-pixel clear, and tracks column and row position. It reports when a full IWIDTH×IWIDTH window is available, and applies backpressure outside an active frame. It sits between the camera/pixel source and the row FIFO chain, feeding the Haar window evaluator.

## Interface
- FRAME_WIDTH, 320: pixels per line
- FRAME_HEIGHT, 240: lines per frame
- IWIDTH, 3: window edge; must match the row blocks
- DATA_WIDTH, 8: pixel width
- clk_os  in  1  single clock
- reset_os  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse marking a new frame
- pix_valid  in  1  source has a pixel
- pix_data  in  DATA_WIDTH  pixel value
- pix_ready  out  1  controller accepts a pixel this cycle
- row_wen  out  1  write enable to all row blocks
- row_clear  out  1  clear for row integral registers; only meaningful with row_wen
- row_data  out  DATA_WIDTH  pixel forwarded to the first row block
- win_valid  out  1  window at (win_x, win_y) is complete in the row registers
- win_x  out  $clog2(FRAME_WIDTH)  window left column
- win_y  out  $clog2(FRAME_HEIGHT)  window top line
- frame_done  out  1  one-cycle pulse after the last pixel
- frame_abort  out  1  one-cycle pulse when a frame restarts mid-frame

## Operation
- Accept = pix_valid & pix_ready. Each accepted pixel gives row_wen=1 and row_data=pix_data in the same cycle, combinationally.
- Counters col (0..FRAME_WIDTH-1) and row (0..FRAME_HEIGHT-1) advance on accept. col wraps to 0 and row increments at col=FRAME_WIDTH-1.
- row_clear=1 only on the first accepted pixel of a frame (col=0, row=0). This clears integrals and writes that pixel in one cycle; no pad entry enters the FIFOs.
- States:
  - IDLE: pix_ready=0. frame_start moves to FILL.
  - FILL: row<IWIDTH-1, pix_ready=1. Accepting the last pixel of line IWIDTH-2 moves to SCAN.
  - SCAN: pix_ready=1. Accepting pixel (FRAME_HEIGHT-1, FRAME_WIDTH-1) moves to DONE.
  - DONE: pix_ready=0. frame_done=1 for one cycle, then IDLE.
- A window is produced for an accepted pixel in SCAN with col≥IWIDTH-1. Then win_x=col-(IWIDTH-1) and win_y=row-(IWIDTH-1).
- Windows per frame = (FRAME_WIDTH-IWIDTH+1)×(FRAME_HEIGHT-IWIDTH+1).
- frame_start in FILL or SCAN:
  - Counters go to 0, the state goes to FILL, and frame_abort pulses.
  - A pixel offered in that cycle is not accepted (pix_ready=0 that cycle).
  - The next accepted pixel carries row_clear.
- frame_start in DONE is held pending and taken on the DONE→IDLE edge. The state goes straight to FILL; no frame is lost.
- pix_valid in IDLE or DONE is ignored, with no counter change.

## Timing
- reset_os has priority over all inputs and takes effect at the next edge.
- Reset state: IDLE, col=row=0, pending start=0.
- Reset values of the registered outputs: win_valid=0, win_x=0, win_y=0, frame_done=0, frame_abort=0.
- Reset values of the combinational outputs: pix_ready=0, row_wen=0, row_clear=0, row_data=pix_data.
- row_wen, row_clear and row_data are combinational from the accept; latency 0.
- win_valid, win_x and win_y are registered, asserted the cycle after the accepting edge. This matches the row registers updating on that edge.
- frame_done is asserted the cycle after the last accept. frame_abort is asserted the cycle after frame_start.
- frame_start coincident with reset_os is ignored.
- Stalls (pix_valid=0) freeze all counters; win_valid is 0 during stall cycles.

## Structure
- Shared package integral_pkg holds:
  - state enum (IDLE, FILL, SCAN, DONE)
  - width functions COL_W/ROW_W via $clog2
  - the IWIDTH default shared with the row blocks
- One sub-module, raster_counter: the col/row counter pair with enable, clear and wrap, outputting col, row and last_pixel.
- FSM, window-coordinate logic and pulse registers live in the top.
- Target 150–250 lines.

## Test plan
Parameters FRAME_WIDTH=4, FRAME_HEIGHT=4, IWIDTH=3.
- Continuous frame: frame_start then 16 valid pixels.
  - row_clear only on pixel 0, row_wen on all 16.
  - win_valid 4 times, at (0,0), (1,0), (0,1), (1,1).
  - frame_done one cycle after pixel 15, pix_ready=0 afterwards.
- Random stalls on pix_valid (~50%): same 4 windows in the same order, counters frozen while stalled, no extra win_valid.
- pix_valid=1 in IDLE for 10 cycles without frame_start: pix_ready=0, row_wen=0, no window.
- frame_start after pixel 9: frame_abort pulses, that cycle's pixel is refused, and the next accepted pixel has row_clear=1. A following 16-pixel frame yields exactly 4 windows.
- reset_os asserted mid-SCAN: next cycle in IDLE, win_valid=0, pix_ready=0. A subsequent frame behaves as in the first scenario.
- frame_start during DONE: the next frame starts without loss, and its first accepted pixel has row_clear=1.

Source files
------------

// File: rtl/integral_pkg.sv
// Shared definitions for the integral-image row pipeline: controller state
// encoding, counter width helpers and the window edge shared with the row blocks.
package integral_pkg;

    // Window edge; the row blocks must be built with the same value.
    localparam int IWIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Column counter width; never narrower than one bit.
    function automatic int COL_W(input int frame_width);
        return (frame_width > 1) ? $clog2(frame_width) : 1;
    endfunction

    // Row counter width; never narrower than one bit.
    function automatic int ROW_W(input int frame_height);
        return (frame_height > 1) ? $clog2(frame_height) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter for a raster scan. Advances on enable, wraps the
// column at the end of a line and the row at the end of the frame.
module raster_counter
    import integral_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    localparam int CW = COL_W(FRAME_WIDTH),
    localparam int RW = ROW_W(FRAME_HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_pixel_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          line_end;
    logic          frame_end;

    assign line_end     = (col_q == CW'(FRAME_WIDTH - 1));
    assign frame_end    = (row_q == RW'(FRAME_HEIGHT - 1));
    assign last_pixel_o = line_end && frame_end;
    assign col_o        = col_q;
    assign row_o        = row_q;

    // Position update: clear has priority over advance; wrap at line/frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            if (line_end) begin
                col_q <= '0;
                row_q <= frame_end ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/integral_row_sequencer.sv
// Raster-scan controller feeding the integral-image row block chain. Generates
// per-pixel write enables and the first-pixel clear, reports complete
// IWIDTH x IWIDTH windows and holds the source off outside an active frame.
//
// Handshake: a pixel transfers on a cycle where pix_valid and pix_ready are
// both 1; pix_ready never depends on pix_valid, and the source may hold or
// drop pix_valid freely while pix_ready is 0.
module integral_row_sequencer
    import integral_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int IWIDTH       = IWIDTH_DEFAULT,
    parameter int DATA_WIDTH   = 8,
    localparam int CW = COL_W(FRAME_WIDTH),
    localparam int RW = ROW_W(FRAME_HEIGHT)
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  row_wen,
    output logic                  row_clear,
    output logic [DATA_WIDTH-1:0] row_data,
    output logic                  win_valid,
    output logic [CW-1:0]         win_x,
    output logic [RW-1:0]         win_y,
    output logic                  frame_done,
    output logic                  frame_abort,
    output state_t                dbg_state_o
);

    state_t        state_q;
    logic          win_valid_q;
    logic [CW-1:0] win_x_q;
    logic [RW-1:0] win_y_q;
    logic          frame_done_q;
    logic          frame_abort_q;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_pixel;
    logic          in_frame;
    logic          accept;
    logic          fill_last;
    logic          win_hit;

    raster_counter #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .FRAME_HEIGHT(FRAME_HEIGHT)
    ) u_raster_counter (
        .clk_i       (clk_os),
        .rst_i       (reset_os),
        .en_i        (accept),
        .clr_i       (frame_start),
        .col_o       (col),
        .row_o       (row),
        .last_pixel_o(last_pixel)
    );

    // A restarting frame refuses the pixel offered in the restart cycle.
    assign in_frame  = (state_q == ST_FILL) || (state_q == ST_SCAN);
    assign pix_ready = in_frame && !frame_start && !reset_os;
    assign accept    = pix_valid && pix_ready;

    // Clear and first write share one cycle so no pad entry enters the FIFOs.
    assign row_wen   = accept;
    assign row_clear = accept && (col == '0) && (row == '0);
    assign row_data  = pix_data;

    assign fill_last = (col == CW'(FRAME_WIDTH - 1)) && (row == RW'(IWIDTH - 2));
    assign win_hit   = accept && (state_q == ST_SCAN) && (col >= CW'(IWIDTH - 1));

    assign win_valid   = win_valid_q;
    assign win_x       = win_x_q;
    assign win_y       = win_y_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign dbg_state_o = state_q;

    // Frame FSM plus registered window coordinates and status pulses. DONE lasts
    // a single cycle, so a start seen there is taken on the way out of DONE.
    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            state_q       <= ST_IDLE;
            win_valid_q   <= 1'b0;
            win_x_q       <= '0;
            win_y_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            win_valid_q   <= win_hit;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            if (win_hit) begin
                win_x_q <= col - CW'(IWIDTH - 1);
                win_y_q <= row - RW'(IWIDTH - 1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (frame_start) begin
                        frame_abort_q <= 1'b1;
                    end else if (accept && fill_last) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (frame_start) begin
                        frame_abort_q <= 1'b1;
                        state_q       <= ST_FILL;
                    end else if (accept && last_pixel) begin
                        frame_done_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= frame_start ? ST_FILL : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integral_row_sequencer.sv
// Bench for integral_row_sequencer on a 4x4 frame with a 3x3 window.
module tb_integral_row_sequencer;
    import integral_pkg::*;

    localparam int FW  = 4;
    localparam int FH  = 4;
    localparam int IW  = 3;
    localparam int NPX = FW * FH;
    localparam int WPF = (FW - IW + 1) * (FH - IW + 1);

    // ---------------- clock / reset ----------------
    logic       clk_os = 1'b0;
    logic       reset_os = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       pix_ready, row_wen, row_clear, win_valid, frame_done, frame_abort;
    logic [7:0] row_data;
    logic [1:0] win_x;
    logic [1:0] win_y;
    state_t     dbg_state;

    always #5 clk_os = ~clk_os;

    integral_row_sequencer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .IWIDTH      (IW),
        .DATA_WIDTH  (8)
    ) dut (
        .clk_os     (clk_os),
        .reset_os   (reset_os),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .row_wen    (row_wen),
        .row_clear  (row_clear),
        .row_data   (row_data),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .dbg_state_o(dbg_state)
    );

    // ---------------- reference model + scoreboard ----------------
    int total = 0;
    int bad = 0;
    int m_phase = 0;   // 0 idle, 1 inside a frame, 2 frame just finished
    int m_n = 0;       // accepted pixels in the current frame
    int win_cnt = 0;
    logic [3:0] exp_q[$];  // expected windows as {y, x}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs, check same-cycle outputs, advance the
    // model across the edge, then check the registered outputs.
    task automatic step(input logic rst, input logic fs, input logic pv, input logic [7:0] pd);
        logic e_ready, e_wen, e_clr, e_wv, e_done, e_abort;
        int r, c, e_state;
        logic [3:0] w;
        @(negedge clk_os);
        reset_os = rst; frame_start = fs; pix_valid = pv; pix_data = pd;
        #1;
        e_ready = !rst && (m_phase == 1) && !fs;
        e_wen   = e_ready && pv;
        e_clr   = e_wen && (m_n == 0);
        if (!rst) chk("pix_ready", pix_ready, e_ready);
        chk("row_wen", row_wen, e_wen);
        chk("row_clear", row_clear, e_clr);
        chk("row_data", row_data, pd);
        e_wv = 0; e_done = 0; e_abort = 0;
        if (rst) begin
            m_phase = 0; m_n = 0; exp_q.delete();
        end else begin
            case (m_phase)
                0: if (fs) begin m_phase = 1; m_n = 0; end
                1: begin
                    if (fs) begin
                        m_n = 0; e_abort = 1;
                    end else if (e_wen) begin
                        r = m_n / FW; c = m_n % FW;
                        if (r >= IW - 1 && c >= IW - 1) begin
                            e_wv = 1;
                            exp_q.push_back({2'(r - (IW - 1)), 2'(c - (IW - 1))});
                        end
                        m_n++;
                        if (m_n == NPX) begin m_phase = 2; m_n = 0; e_done = 1; end
                    end
                end
                default: begin m_phase = fs ? 1 : 0; m_n = 0; end
            endcase
        end
        @(posedge clk_os);
        #1;
        chk("win_valid", win_valid, e_wv);
        chk("frame_done", frame_done, e_done);
        chk("frame_abort", frame_abort, e_abort);
        if (m_phase == 0) e_state = 0;
        else if (m_phase == 2) e_state = 3;
        else e_state = (m_n < (IW - 1) * FW) ? 1 : 2;
        chk("state", dbg_state, e_state);
        if (win_valid) begin
            win_cnt++;
            chk("win_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("win_xy", {win_y, win_x}, w);
            end
        end
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 8'($urandom_range(0, 255)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h5a);   // start coincident with reset is ignored
        chk("reset_win_x", win_x, 0);
        chk("reset_win_y", win_y, 0);

        // continuous frame
        win_cnt = 0;
        step(0, 1, 0, 8'h00);
        pixels(NPX);
        pixels(3);              // DONE then IDLE: pixels refused
        chk("frame1_windows", win_cnt, WPF);

        // random stalls
        win_cnt = 0;
        step(0, 1, 0, 8'h00);
        guard = 0;
        while (m_phase == 1 && guard < 400) begin
            step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            guard++;
        end
        chk("stall_budget", guard < 400, 1);
        step(0, 0, 0, 8'h00);
        chk("stall_windows", win_cnt, WPF);

        // valid pixels in IDLE with no start
        win_cnt = 0;
        pixels(10);
        chk("idle_windows", win_cnt, 0);

        // restart after pixel 9, then a full frame
        step(0, 1, 0, 8'h00);
        pixels(10);
        step(0, 1, 1, 8'h77);   // abort, pixel refused
        win_cnt = 0;
        pixels(NPX);
        step(0, 0, 1, 8'h11);
        chk("abort_frame_windows", win_cnt, WPF);

        // reset in SCAN, then a normal frame
        step(0, 1, 0, 8'h00);
        pixels(11);
        step(1, 1, 1, 8'h33);
        pixels(2);
        win_cnt = 0;
        step(0, 1, 0, 8'h00);
        pixels(NPX);
        step(0, 0, 1, 8'h22);
        chk("post_reset_windows", win_cnt, WPF);

        // start during DONE: back-to-back frames
        win_cnt = 0;
        step(0, 1, 0, 8'h00);
        pixels(NPX);
        step(0, 1, 1, 8'h44);   // DONE cycle with start
        pixels(NPX);
        step(0, 0, 1, 8'h55);
        chk("b2b_windows", win_cnt, 2 * WPF);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
